// File: rtl/compr_packer_if.sv
// Bundle of instruction-in, flush/start control and memory-write signals for compr_packer.
// The slave modport is the packer's view; master is the loader/memory side.
interface compr_packer_if #(
    parameter int unsigned ADDR_W = 64
);
    logic              i_start;
    logic [ADDR_W-1:0] i_start_addr;
    logic              i_instr_valid;
    logic [31:0]       i_instr;
    logic              o_instr_ready;
    logic              i_flush;
    logic              o_wr_valid;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [31:0]       o_wr_data;
    logic [3:0]        o_wr_be;
    logic              i_wr_ready;
    logic              o_busy;

    modport slave (
        input  i_start, i_start_addr, i_instr_valid, i_instr, i_flush, i_wr_ready,
        output o_instr_ready, o_wr_valid, o_wr_addr, o_wr_data, o_wr_be, o_busy
    );

    modport master (
        output i_start, i_start_addr, i_instr_valid, i_instr, i_flush, i_wr_ready,
        input  o_instr_ready, o_wr_valid, o_wr_addr, o_wr_data, o_wr_be, o_busy
    );
endinterface

// File: rtl/compr_packer.sv
// Packs a stream of 16/32-bit RV64C instructions into aligned 32-bit I-mem words with
// byte enables; a 32-bit instruction may straddle two words.
module compr_packer #(
    parameter int unsigned       ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic           clk,
    input  logic           rst,
    compr_packer_if.slave  bus
);
    typedef enum logic [1:0] {
        ALIGNED = 2'd0,
        HALF    = 2'd1,
        HALF_E  = 2'd2
    } state_e;

    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

    state_e            state_q, state_d;
    logic [15:0]       buf_q, buf_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic [3:0]        wr_be_q, wr_be_d;

    logic out_free;
    logic instr_fire;
    logic flush_fire;
    logic is_c;

    assign out_free          = !wr_valid_q || bus.i_wr_ready;
    assign bus.o_instr_ready = !bus.i_start && !bus.i_flush && out_free;
    assign instr_fire        = bus.i_instr_valid && bus.o_instr_ready;
    assign flush_fire        = bus.i_flush && !bus.i_start && out_free;
    assign is_c              = bus.i_instr[1:0] != 2'b11;

    assign bus.o_wr_valid = wr_valid_q;
    assign bus.o_wr_addr  = wr_addr_q;
    assign bus.o_wr_data  = wr_data_q;
    assign bus.o_wr_be    = wr_be_q;
    assign bus.o_busy     = (state_q == HALF) || wr_valid_q;

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        ptr_d      = ptr_q;
        wr_valid_d = wr_valid_q && !bus.i_wr_ready;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_be_d    = wr_be_q;

        // Start discards any held half but leaves an issued write to drain.
        if (bus.i_start) begin
            ptr_d   = bus.i_start_addr & WORD_MASK;
            state_d = bus.i_start_addr[1] ? HALF_E : ALIGNED;
            buf_d   = '0;
        end else if (flush_fire) begin
            case (state_q)
                HALF: begin
                    wr_valid_d = 1'b1;
                    wr_addr_d  = ptr_q;
                    wr_data_d  = {16'h0000, buf_q};
                    wr_be_d    = 4'b0011;
                    ptr_d      = ptr_q + WORD_STEP;
                    state_d    = ALIGNED;
                end
                HALF_E: begin
                    ptr_d   = ptr_q + WORD_STEP;
                    state_d = ALIGNED;
                end
                default: state_d = ALIGNED;
            endcase
        end else if (instr_fire) begin
            case (state_q)
                ALIGNED: begin
                    if (is_c) begin
                        buf_d   = bus.i_instr[15:0];
                        state_d = HALF;
                    end else begin
                        wr_valid_d = 1'b1;
                        wr_addr_d  = ptr_q;
                        wr_data_d  = bus.i_instr;
                        wr_be_d    = 4'b1111;
                        ptr_d      = ptr_q + WORD_STEP;
                    end
                end
                HALF: begin
                    wr_valid_d = 1'b1;
                    wr_addr_d  = ptr_q;
                    wr_data_d  = {bus.i_instr[15:0], buf_q};
                    wr_be_d    = 4'b1111;
                    ptr_d      = ptr_q + WORD_STEP;
                    if (is_c) begin
                        state_d = ALIGNED;
                    end else begin
                        buf_d = bus.i_instr[31:16];
                    end
                end
                HALF_E: begin
                    wr_valid_d = 1'b1;
                    wr_addr_d  = ptr_q;
                    wr_data_d  = {bus.i_instr[15:0], 16'h0000};
                    wr_be_d    = 4'b1100;
                    ptr_d      = ptr_q + WORD_STEP;
                    if (is_c) begin
                        state_d = ALIGNED;
                    end else begin
                        buf_d   = bus.i_instr[31:16];
                        state_d = HALF;
                    end
                end
                default: state_d = ALIGNED;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ALIGNED;
            buf_q      <= '0;
            ptr_q      <= BASE_ADDR & WORD_MASK;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_be_q    <= '0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            ptr_q      <= ptr_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_be_q    <= wr_be_d;
        end
    end
endmodule
